// File: rtl/systolic_pkg.sv
// Constants and types shared by the systolic array feeder and collector.
package systolic_pkg;

    localparam int SAMPLE_W = 8;
    localparam int WORD_W   = 56;
    localparam int SAMPLES  = WORD_W / SAMPLE_W;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic {
        HOLD_EMPTY = 1'b0,
        HOLD_FULL  = 1'b1
    } hold_state_t;

endpackage

// File: rtl/word_hold_reg.sv
// Output register for assembled words: valid/ready handshake, drop-on-full
// detection and sticky overflow flag.
//
// state      | meaning
// HOLD_EMPTY | no unconsumed word; a load is captured
// HOLD_FULL  | data holds a word; a load is taken only if it leaves this edge
module word_hold_reg
    import systolic_pkg::*;
#(
    parameter int width = WORD_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [width-1:0] load_data,
    input  logic             ready,
    input  logic             clear_ovf,
    output logic [width-1:0] data,
    output logic             valid,
    output logic             overflow
);

    hold_state_t      state_q;
    hold_state_t      state_d;
    logic [width-1:0] data_d;
    logic             ovf_d;

    always_comb begin
        state_d = state_q;
        data_d  = data;
        ovf_d   = overflow;
        case (state_q)
            HOLD_EMPTY: begin
                if (load) begin
                    state_d = HOLD_FULL;
                    data_d  = load_data;
                end
            end
            HOLD_FULL: begin
                if (ready) begin
                    if (load) begin
                        data_d = load_data;
                    end else begin
                        state_d = HOLD_EMPTY;
                    end
                end else if (load) begin
                    // Held word is never overwritten; the newcomer is lost.
                    ovf_d = 1'b1;
                end
            end
        endcase
        if (clear_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= HOLD_EMPTY;
            data     <= '0;
            overflow <= 1'b0;
        end else begin
            state_q  <= state_d;
            data     <= data_d;
            overflow <= ovf_d;
        end
    end

    assign valid = (state_q == HOLD_FULL);

endmodule

// File: rtl/data_collector.sv
// Deserializer at the systolic array output edge: packs samples MSB-first
// into words and presents them through a valid/ready hold register.
module data_collector
    import systolic_pkg::*;
#(
    parameter int in_width  = SAMPLE_W,
    parameter int out_width = WORD_W
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic signed [in_width-1:0]                  data_in,
    input  logic                                        capture,
    input  logic                                        flush,
    input  logic                                        clear,
    input  logic                                        word_ready,
    output logic [out_width-1:0]                        word_out,
    output logic                                        word_valid,
    output logic [$clog2(out_width/in_width+1)-1:0]     count,
    output logic                                        overflow
);

    localparam int N_SAMP = out_width / in_width;
    localparam int CNT_W  = $clog2(N_SAMP + 1);

    logic [out_width-1:0] asm_q;
    logic [out_width-1:0] asm_cap;
    logic [out_width-1:0] word_pad;
    logic [CNT_W-1:0]     cnt_cap;
    logic                 complete;
    int                   pad_bits;

    // asm_cap/cnt_cap are the post-capture view, so a flush in the same
    // cycle as a capture closes the word including that sample.
    always_comb begin
        asm_cap = asm_q;
        cnt_cap = count;
        if (capture) begin
            asm_cap = {asm_q[out_width-in_width-1:0], data_in};
            cnt_cap = count + CNT_W'(1);
        end
        complete = !clear &&
                   ((cnt_cap == CNT_W'(N_SAMP)) || (flush && (cnt_cap != '0)));
        pad_bits = in_width * (N_SAMP - int'(cnt_cap));
        word_pad = asm_cap << pad_bits;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            asm_q <= '0;
            count <= '0;
        end else if (clear || complete) begin
            asm_q <= '0;
            count <= '0;
        end else begin
            asm_q <= asm_cap;
            count <= cnt_cap;
        end
    end

    word_hold_reg #(
        .width (out_width)
    ) u_hold (
        .clk       (clk),
        .reset     (reset),
        .load      (complete),
        .load_data (word_pad),
        .ready     (word_ready),
        .clear_ovf (clear),
        .data      (word_out),
        .valid     (word_valid),
        .overflow  (overflow)
    );

endmodule

// File: doc/data_collector.md
# data_collector

Deserializer at the output edge of the systolic MAC array: the inverse of the data feeder. It captures one signed `in_width`-bit sample per `capture` strobe and packs `out_width/in_width` samples MSB-first into one word. It presents the completed word on a valid/ready output held in an output register. A word serialized by the feeder and collected here, strobe for strobe, reassembles bit-identical.

## Interface
- `in_width`, 8, sample width in bits.
- `out_width`, 56, assembled word width; must be an integer multiple of `in_width`. SAMPLES = `out_width/in_width` (7).

- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `data_in` input signed [in_width-1:0]: sample from array edge.
- `capture` input 1: sample `data_in` this edge.
- `flush` input 1: close the partial word, zero-padding the low bytes.
- `clear` input 1: synchronous discard of the partial word; clears `overflow`.
- `word_ready` input 1: downstream accepts `word_out` when `word_valid` is high.
- `word_out` output [out_width-1:0]: assembled word.
- `word_valid` output 1: `word_out` holds an unconsumed word.
- `count` output [$clog2(SAMPLES+1)-1:0]: samples in the partial word, 0..SAMPLES-1.
- `overflow` output 1: sticky flag; a completed word was dropped.

## Operation
- Assembly register `asm`, `out_width` bits: on capture, `asm <= {asm[out_width-in_width-1:0], data_in}` and `count++`. The first sample ends in bits [out_width-1 -: in_width].
- Completion:
  - Capture with `count == SAMPLES-1` completes the word `{asm[...], data_in}`. `count` returns to 0.
  - Flush with `count' > 0`, where `count'` is the count after any same-cycle capture, completes the word `asm' << (in_width*(SAMPLES-count'))` (zero pad). `count` returns to 0.
  - Flush with `count' == 0` is a no-op.
- Output handshake: a transfer occurs at an edge where `word_valid && word_ready`.
  - Completion when `!word_valid`: load `word_out`, set `word_valid`.
  - Completion with a same-cycle transfer: load the new word; `word_valid` stays 1.
  - Completion when `word_valid && !word_ready`: the new word is dropped; `word_out` is unchanged; `overflow` is set.
  - Transfer with no completion: clear `word_valid`; `word_out` keeps its last value.
- Two states for assembly, derived from `count`: FILL (count > 0) and EMPTY (count == 0). `word_valid` is the output state bit.
- Priority: `clear` > `flush`/`capture`.
  - `clear` zeroes `asm` and `count` and clears `overflow`.
  - `clear` leaves `word_out` and `word_valid` untouched. A handshake in the same cycle still completes.
  - A capture or flush in the same cycle as `clear` is ignored.
- Simultaneous `capture` and `flush` in one cycle: the sample is included first, then the word is padded. With `count == SAMPLES-1` this is a normal completion; the flush adds nothing.

## Timing
- On reset assertion, asynchronously: `asm=0`, `count=0`, `word_out=0`, `word_valid=0`, `overflow=0`.
- Reset mid-word discards the partial word and any held word.
- Latency: `word_valid` rises at the same edge that samples the completing capture or flush. It is visible one cycle after that strobe is presented.
- `count` updates at the capture edge.
- `word_out` is stable whenever `word_valid=1` until the transfer edge.
- Sustained capture every cycle with `word_ready` tied high produces one word every SAMPLES cycles with no loss.
- `overflow` rises at the dropping edge and holds until `clear` or reset.

## Structure
- Shared package `systolic_pkg`: `SAMPLE_W=8`, `WORD_W=56`, `SAMPLES=WORD_W/SAMPLE_W`, and a `sample_t` signed typedef. The feeder and collector share these constants.
- Sub-module `word_hold_reg` (`out_width` data, valid/ready register with load/accept/drop logic, overflow detect). The top level holds `asm`, `count`, and the pad shifter.

## Test plan
- Full word: capture 0x11,0x22,...,0x77 on 7 consecutive cycles, `word_ready=0` -> `word_out=0x11223344556677`, `word_valid=1` after the 7th, `count=0`.
- Flush partial: capture 0xAA,0xBB,0xCC then `flush` -> `word_out=0xAABBCC00000000`. Flush again with `count=0` -> no change.
- Overflow: hold `word_ready=0` and complete two words -> the first word is retained, `overflow=1`. `clear` -> `overflow=0`, `word_valid` still 1.
- Back-to-back: capture every cycle for 21 cycles with `word_ready=1` -> exactly 3 words, no overflow, `word_valid` deasserted only between words.
- Simultaneous events:
  - `capture`+`flush` with `count=2` -> 3-sample padded word.
  - `clear`+`capture` -> sample ignored, `count=0`.
- Reset mid-operation: drive `reset` low after 4 captures with a word held -> all outputs 0 immediately. Then a fresh 7-capture word is correct.
- Round trip: data_feeder loaded with random 56-bit W, collector captures `data_out` on each of 7 shifts, starting with the cycle after load -> `word_out==W`, over 100 random words.
